// File: rtl/cam_fb_pkg.sv
// Shared definitions for the camera-to-VGA frame buffer.
// Provides the pixel width helper, coordinate width, background fill bit,
// write FSM state type and the frame buffer address builder.
package cam_fb_pkg;

  localparam int unsigned CoordW = 10;

  // Every bit of the default background takes this value.
  localparam bit BgFill = 1'b0;

  typedef enum logic [1:0] {StIdle, StFill, StHold} wr_state_e;

  function automatic int unsigned pix_width(input int unsigned ch, input int unsigned cw);
    return ch * cw;
  endfunction

  // {bank, yi[hlg-1:0], xi[wlg-1:0]}; callers truncate to the RAM address width.
  function automatic logic [31:0] fb_addr(input logic bank, input logic [31:0] yi,
                                          input logic [31:0] xi, input int unsigned wlg,
                                          input int unsigned hlg);
    logic [31:0] xmask;
    logic [31:0] ymask;
    xmask = (32'd1 << wlg) - 32'd1;
    ymask = (32'd1 << hlg) - 32'd1;
    return ({31'd0, bank} << (wlg + hlg)) | ((yi & ymask) << wlg) | (xi & xmask);
  endfunction

endpackage

// File: rtl/cam_fb_dpram.sv
// Simple dual-port RAM: one write port, one read port, synchronous read
// with one cycle of latency, no reset on the array or read data.
//   m_clock - clock
//   we/waddr/wdata - write port
//   raddr/rdata    - read port (rdata valid the cycle after raddr)
module cam_fb_dpram #(
  parameter int unsigned DW = 12,
  parameter int unsigned AW = 15
) (
  input  logic          m_clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge m_clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cam_vga_fb.sv
// Camera-to-VGA ping-pong frame buffer.
// The camera fills the write bank while VGA displays the read bank; a
// completed frame is swapped in on the next VGA start-of-frame, so a frame is
// never shown half written. Frames arriving while one is still waiting are
// dropped and counted.
//   m_clock, p_reset                  - clock, async active-low reset
//   cam_x/cam_y/cam_valid/cam_pix     - camera pixel stream with plot coords
//   cam_sof/cam_eof                   - camera frame markers
//   vga_x/vga_y/vga_sof               - VGA scan position and frame start
//   pix_out/pix_in_win                - display pixel, 2 cycles after vga_x/y
//   rd_bank/frame_ready/drop_cnt      - buffer status
module cam_vga_fb
  import cam_fb_pkg::*;
#(
  parameter int unsigned CH     = 3,
  parameter int unsigned CW     = 4,
  parameter int unsigned WLG    = 7,
  parameter int unsigned HLG    = 7,
  parameter int unsigned DEC_SH = 0,
  parameter int unsigned REP_SH = 0,
  parameter int unsigned H_OFS  = 7,
  parameter int unsigned V_OFS  = 0,
  parameter logic [pix_width(CH, CW)-1:0] BG = {(pix_width(CH, CW)){BgFill}}
) (
  input  logic                         m_clock,
  input  logic                         p_reset,
  input  logic [CoordW-1:0]            cam_x,
  input  logic [CoordW-1:0]            cam_y,
  input  logic                         cam_valid,
  input  logic [pix_width(CH, CW)-1:0] cam_pix,
  input  logic                         cam_sof,
  input  logic                         cam_eof,
  input  logic [CoordW-1:0]            vga_x,
  input  logic [CoordW-1:0]            vga_y,
  input  logic                         vga_sof,
  output logic [pix_width(CH, CW)-1:0] pix_out,
  output logic                         pix_in_win,
  output logic                         rd_bank,
  output logic                         frame_ready,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned PW = pix_width(CH, CW);
  localparam int unsigned AW = WLG + HLG + 1;
  localparam logic [CoordW-1:0] DecMask = CoordW'((32'd1 << DEC_SH) - 32'd1);
  localparam logic [10:0] HOfs = 11'(H_OFS);
  localparam logic [10:0] VOfs = 11'(V_OFS);

  wr_state_e  state_q, state_d;
  logic       rd_bank_q, rd_bank_d;
  logic       wr_bank_q, wr_bank_d;
  logic       ready_q, ready_d;
  logic [7:0] drop_q, drop_d;
  logic       swap;

  // A waiting frame is swapped in at VGA frame start, never mid-scan.
  assign swap = vga_sof & ready_q;

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    ready_d   = ready_q;
    drop_d    = drop_q;
    if (swap) begin
      rd_bank_d = wr_bank_q;
      wr_bank_d = rd_bank_q;
      ready_d   = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (cam_sof) state_d = StFill;
      end
      StFill: begin
        // cam_sof here simply restarts the same bank; ready is never set in FILL,
        // so no swap can race with cam_eof.
        if (cam_eof) begin
          state_d = StHold;
          ready_d = 1'b1;
        end
      end
      StHold: begin
        if (cam_sof) begin
          if (ready_q && !swap) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q   <= StIdle;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b1;
      ready_q   <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      ready_q   <= ready_d;
      drop_q    <= drop_d;
    end
  end

  // Write side: decimate, then reject anything beyond the window instead of wrapping.
  logic [CoordW-1:0] cam_xi, cam_yi;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;

  assign cam_xi  = cam_x >> DEC_SH;
  assign cam_yi  = cam_y >> DEC_SH;
  assign wr_en   = (state_q == StFill) && cam_valid &&
                   ((cam_x & DecMask) == '0) && ((cam_y & DecMask) == '0) &&
                   ((cam_xi >> WLG) == '0) && ((cam_yi >> HLG) == '0);
  assign wr_addr = AW'(fb_addr(wr_bank_q, 32'(cam_yi), 32'(cam_xi), WLG, HLG));

  // Read side: bit 10 of the 11-bit difference is the sign, so scan positions
  // left of / above the window never alias into it.
  logic [10:0]       dx, dy;
  logic [CoordW-1:0] rd_xi, rd_yi;
  logic              in_win;
  logic [AW-1:0]     rd_addr;
  logic [PW-1:0]     ram_q;
  logic              in_win_q;
  logic [PW-1:0]     pix_q;
  logic              pix_in_win_q;

  assign dx      = {1'b0, vga_x} - HOfs;
  assign dy      = {1'b0, vga_y} - VOfs;
  assign in_win  = !dx[10] && !dy[10] &&
                   ((dx[9:0] >> (WLG + REP_SH)) == '0) && ((dy[9:0] >> (HLG + REP_SH)) == '0);
  assign rd_xi   = dx[9:0] >> REP_SH;
  assign rd_yi   = dy[9:0] >> REP_SH;
  assign rd_addr = AW'(fb_addr(rd_bank_q, 32'(rd_yi), 32'(rd_xi), WLG, HLG));

  cam_fb_dpram #(
    .DW(PW),
    .AW(AW)
  ) u_ram (
    .m_clock(m_clock),
    .we     (wr_en),
    .waddr  (wr_addr),
    .wdata  (cam_pix),
    .raddr  (rd_addr),
    .rdata  (ram_q)
  );

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      in_win_q     <= 1'b0;
      pix_q        <= BG;
      pix_in_win_q <= 1'b0;
    end else begin
      in_win_q     <= in_win;
      pix_q        <= in_win_q ? ram_q : BG;
      pix_in_win_q <= in_win_q;
    end
  end

  assign pix_out     = pix_q;
  assign pix_in_win  = pix_in_win_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = ready_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_cam_vga_fb.sv
module tb_cam_vga_fb;

  logic m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  // Default-parameter instance.
  logic       p_reset;
  logic [9:0] cam_x, cam_y, vga_x, vga_y;
  logic       cam_valid, cam_sof, cam_eof, vga_sof;
  logic [11:0] cam_pix, pix_out;
  logic       pix_in_win, rd_bank, frame_ready;
  logic [7:0] drop_cnt;

  // Decimating / replicating instance.
  logic       p_reset2;
  logic [9:0] cam_x2, cam_y2, vga_x2, vga_y2;
  logic       cam_valid2, cam_sof2, cam_eof2, vga_sof2;
  logic [7:0] cam_pix2, pix_out2;
  logic       pix_in_win2, rd_bank2, frame_ready2;
  logic [7:0] drop_cnt2;

  cam_vga_fb u_dut (
    .m_clock(m_clock), .p_reset(p_reset), .cam_x(cam_x), .cam_y(cam_y),
    .cam_valid(cam_valid), .cam_pix(cam_pix), .cam_sof(cam_sof), .cam_eof(cam_eof),
    .vga_x(vga_x), .vga_y(vga_y), .vga_sof(vga_sof), .pix_out(pix_out),
    .pix_in_win(pix_in_win), .rd_bank(rd_bank), .frame_ready(frame_ready),
    .drop_cnt(drop_cnt)
  );

  cam_vga_fb #(
    .CH(1), .CW(8), .WLG(6), .HLG(6), .DEC_SH(1), .REP_SH(1)
  ) u_dut2 (
    .m_clock(m_clock), .p_reset(p_reset2), .cam_x(cam_x2), .cam_y(cam_y2),
    .cam_valid(cam_valid2), .cam_pix(cam_pix2), .cam_sof(cam_sof2), .cam_eof(cam_eof2),
    .vga_x(vga_x2), .vga_y(vga_y2), .vga_sof(vga_sof2), .pix_out(pix_out2),
    .pix_in_win(pix_in_win2), .rd_bank(rd_bank2), .frame_ready(frame_ready2),
    .drop_cnt(drop_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the image each bank holds, which bank is shown, buffer status.
  logic [11:0] img [2][16384];
  bit          m_rd;
  bit          m_ready;
  logic [7:0]  m_drop;
  // Second instance: the single frame it captured, as a 64x64 stored image.
  logic [7:0]  mem2 [4096];
  bit          m_rd2;
  bit          m_ready2;
  logic [7:0]  m_drop2;

  function automatic logic [12:0] ref1(input int x, input int y);
    int dx;
    dx = x - 7;
    if (dx >= 0 && dx < 128 && y >= 0 && y < 128) return {1'b1, img[m_rd][y * 128 + dx]};
    return 13'h0;
  endfunction

  function automatic logic [8:0] ref2(input int x, input int y);
    int dx;
    dx = x - 7;
    if (dx >= 0 && dx < 128 && y >= 0 && y < 128) return {1'b1, mem2[(y / 2) * 64 + dx / 2]};
    return 9'h0;
  endfunction

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic check_stat1(input string name);
    n_cmp++;
    if ({rd_bank, frame_ready, drop_cnt} !== {m_rd, m_ready, m_drop}) begin
      n_bad++;
      $display("FAIL %s: rd_bank/ready/drops got %b/%b/%0d want %b/%b/%0d", name, rd_bank,
               frame_ready, drop_cnt, m_rd, m_ready, m_drop);
    end
  endtask

  task automatic check_stat2(input string name);
    n_cmp++;
    if ({rd_bank2, frame_ready2, drop_cnt2} !== {m_rd2, m_ready2, m_drop2}) begin
      n_bad++;
      $display("FAIL %s: rd_bank/ready/drops got %b/%b/%0d want %b/%b/%0d", name, rd_bank2,
               frame_ready2, drop_cnt2, m_rd2, m_ready2, m_drop2);
    end
  endtask

  // Random scan positions; each result is checked two cycles after it is driven.
  task automatic scan(input bit d2, input int n, input int ymax, input string name);
    logic [12:0] q[$];
    logic [12:0] e, a;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        int x, y;
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                          : int'($urandom_range(0, 140));
        y = int'($urandom_range(0, ymax));
        if (d2) begin
          vga_x2 = 10'(x); vga_y2 = 10'(y); q.push_back({4'h0, ref2(x, y)});
        end else begin
          vga_x = 10'(x); vga_y = 10'(y); q.push_back(ref1(x, y));
        end
      end
      tick();
      if (i >= 1) begin
        e = q.pop_front();
        a = d2 ? {4'h0, pix_in_win2, pix_out2} : {pix_in_win, pix_out};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: in_win/pix got %h want %h (cycle %0d)", name, a, e, i);
        end
      end
    end
  endtask

  task automatic point1(input int x, input int y, input logic [12:0] want, input string name);
    vga_x = 10'(x); vga_y = 10'(y);
    tick(); tick();
    n_cmp++;
    if ({pix_in_win, pix_out} !== want) begin
      n_bad++;
      $display("FAIL %s (%0d,%0d): got %h want %h", name, x, y, {pix_in_win, pix_out}, want);
    end
  endtask

  task automatic pulse_sof1();  cam_sof = 1'b1; tick(); cam_sof = 1'b0; endtask
  task automatic pulse_eof1();  cam_eof = 1'b1; tick(); cam_eof = 1'b0; endtask
  task automatic pulse_vsof1(); vga_sof = 1'b1; tick(); vga_sof = 1'b0; endtask
  task automatic pulse_sof2();  cam_sof2 = 1'b1; tick(); cam_sof2 = 1'b0; endtask
  task automatic pulse_eof2();  cam_eof2 = 1'b1; tick(); cam_eof2 = 1'b0; endtask
  task automatic pulse_vsof2(); vga_sof2 = 1'b1; tick(); vga_sof2 = 1'b0; endtask

  // mode 0: {y,x,x} nibble pattern, 1: constant FFF, 2: random.
  task automatic write_frame(input bit bank, input int mode);
    logic [9:0]  xv, yv;
    logic [11:0] p;
    pulse_sof1();
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 128; x++) begin
        xv = 10'(x); yv = 10'(y);
        p = (mode == 0) ? {yv[3:0], xv[3:0], xv[3:0]} : (mode == 1) ? 12'hFFF : 12'($urandom);
        cam_valid = 1'b1; cam_x = xv; cam_y = yv; cam_pix = p;
        img[bank][y * 128 + x] = p;
        tick();
      end
    end
    // Out-of-window coordinates must be ignored, not wrapped.
    cam_pix = 12'hABC;
    for (int k = 0; k < 4; k++) begin
      cam_x = 10'(128 + k); cam_y = 10'(k); tick();
      cam_x = 10'(k); cam_y = 10'(128 + k); tick();
    end
    cam_x = 10'd1023; cam_y = 10'd1; tick();
    cam_valid = 1'b0;
    pulse_eof1();
  endtask

  task automatic junk_pixels(input int n);
    for (int k = 0; k < n; k++) begin
      cam_valid = 1'b1;
      cam_x = 10'($urandom_range(0, 127)); cam_y = 10'($urandom_range(0, 127));
      cam_pix = 12'($urandom);
      tick();
    end
    cam_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({pix_in_win, pix_out, pix_in_win2, pix_out2} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_pix: got %h/%h %h/%h want 0", pix_in_win, pix_out, pix_in_win2,
               pix_out2);
    end
    check_stat1("reset_stat1");
    check_stat2("reset_stat2");
    pulse_eof1();  // IDLE ignores cam_eof
    check_stat1("idle_eof");
  endtask

  task automatic test_fill();
    write_frame(1'b1, 0);
    m_ready = 1'b1;
    check_stat1("fill_ready");
    pulse_vsof1();
    m_rd = 1'b1; m_ready = 1'b0;
    check_stat1("fill_swap");
    point1(12, 3, 13'h1355, "fill_pix");
    scan(1'b0, 300, 135, "fill_scan");
  endtask

  task automatic test_edges();
    int ex[7] = '{6, 135, 12, 7, 0, 134, 1023};
    int ey[7] = '{3, 3, 128, 0, 0, 127, 5};
    point1(6, 3, 13'h0, "edge_left");
    point1(7, 0, 13'h1000, "edge_origin");
    for (int k = 0; k < 7; k++) point1(ex[k], ey[k], ref1(ex[k], ey[k]), "edge_tbl");
  endtask

  task automatic test_tear_free();
    write_frame(1'b0, 1);
    m_ready = 1'b1;
    check_stat1("tear_ready");
    scan(1'b0, 150, 135, "tear_old");
    pulse_vsof1();
    m_rd = 1'b0; m_ready = 1'b0;
    check_stat1("tear_swap");
    point1(70, 60, 13'h1FFF, "tear_new_pix");
    scan(1'b0, 150, 135, "tear_new");
  endtask

  task automatic test_drop();
    write_frame(1'b1, 2);
    m_ready = 1'b1;
    pulse_sof1(); junk_pixels(40); pulse_eof1();
    pulse_sof1(); junk_pixels(40); pulse_eof1();
    m_drop = 8'd2;
    check_stat1("drop_two");
    pulse_vsof1();
    m_rd = 1'b1; m_ready = 1'b0;
    check_stat1("drop_swap");
    scan(1'b0, 300, 135, "drop_intact");
  endtask

  task automatic test_simultaneous();
    pulse_sof1(); pulse_eof1();
    m_ready = 1'b1;
    check_stat1("sim_ready");
    vga_sof = 1'b1; cam_sof = 1'b1; tick(); vga_sof = 1'b0; cam_sof = 1'b0;
    m_rd = 1'b0; m_ready = 1'b0;
    check_stat1("sim_vsof_csof");
    scan(1'b0, 100, 135, "sim_show0");
    for (int k = 0; k < 200; k++) begin
      int x, y;
      x = int'($urandom_range(0, 127)); y = int'($urandom_range(0, 127));
      cam_valid = 1'b1; cam_x = 10'(x); cam_y = 10'(y); cam_pix = 12'($urandom);
      img[1][y * 128 + x] = cam_pix;
      tick();
    end
    cam_valid = 1'b0;
    vga_sof = 1'b1; cam_eof = 1'b1; tick(); vga_sof = 1'b0; cam_eof = 1'b0;
    m_ready = 1'b1;
    check_stat1("sim_vsof_ceof");
    pulse_vsof1();
    m_rd = 1'b1; m_ready = 1'b0;
    check_stat1("sim_late_swap");
    scan(1'b0, 300, 135, "sim_show1");
  endtask

  task automatic test_drop_saturate();
    pulse_sof1(); pulse_eof1();
    m_ready = 1'b1;
    for (int k = 0; k < 252; k++) pulse_sof1();
    m_drop = 8'd254;
    check_stat1("drop_254");
    for (int k = 0; k < 48; k++) pulse_sof1();
    m_drop = 8'd255;
    check_stat1("drop_sat");
  endtask

  task automatic test_dec_rep();
    logic [7:0] p;
    pulse_sof2();
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 130; x++) begin
        p = (x == 6 && y == 4) ? 8'hA5 : 8'($urandom);
        cam_valid2 = 1'b1; cam_x2 = 10'(x); cam_y2 = 10'(y); cam_pix2 = p;
        if (x % 2 == 0 && y % 2 == 0 && x / 2 < 64) mem2[(y / 2) * 64 + x / 2] = p;
        tick();
      end
    end
    cam_valid2 = 1'b0;
    pulse_eof2();
    m_ready2 = 1'b1;
    pulse_vsof2();
    m_rd2 = 1'b1; m_ready2 = 1'b0;
    check_stat2("dec_swap");
    for (int k = 0; k < 4; k++) begin
      vga_x2 = 10'(13 + k % 2); vga_y2 = 10'(4 + k / 2);
      tick(); tick();
      n_cmp++;
      if ({pix_in_win2, pix_out2} !== 9'h1A5) begin
        n_bad++;
        $display("FAIL dec_rep_pix (%0d,%0d): got %h want 1a5", vga_x2, vga_y2,
                 {pix_in_win2, pix_out2});
      end
    end
    scan(1'b1, 300, 15, "dec_scan");
  endtask

  task automatic test_reset_mid_fill();
    pulse_sof2(); pulse_eof2(); pulse_sof2();
    m_ready2 = 1'b1; m_drop2 = 8'd1;
    check_stat2("rst_drop");
    pulse_vsof2();
    pulse_sof2(); pulse_eof2(); pulse_vsof2();
    m_rd2 = 1'b1; m_ready2 = 1'b0;
    pulse_sof2();
    vga_x2 = 10'd13; vga_y2 = 10'd4;
    tick(); tick();
    check_stat2("rst_before");
    n_cmp++;
    if ({pix_in_win2, pix_out2} !== 9'h1A5) begin
      n_bad++;
      $display("FAIL rst_before_pix: got %h want 1a5", {pix_in_win2, pix_out2});
    end
    p_reset2 = 1'b0;
    #1;
    m_rd2 = 1'b0; m_ready2 = 1'b0; m_drop2 = 8'd0;
    n_cmp++;
    if ({pix_in_win2, pix_out2, rd_bank2, frame_ready2, drop_cnt2} !== 19'h0) begin
      n_bad++;
      $display("FAIL rst_async: in_win/pix/rd/ready/drops got %b/%h/%b/%b/%0d want all 0",
               pix_in_win2, pix_out2, rd_bank2, frame_ready2, drop_cnt2);
    end
    tick();
    p_reset2 = 1'b1;
    tick();
    pulse_eof2();  // back in IDLE, so eof must not mark a frame ready
    check_stat2("rst_idle");
  endtask

  initial begin
    p_reset = 1'b0; p_reset2 = 1'b0;
    cam_x = '0; cam_y = '0; cam_valid = 1'b0; cam_pix = '0; cam_sof = 1'b0; cam_eof = 1'b0;
    vga_x = '0; vga_y = '0; vga_sof = 1'b0;
    cam_x2 = '0; cam_y2 = '0; cam_valid2 = 1'b0; cam_pix2 = '0; cam_sof2 = 1'b0;
    cam_eof2 = 1'b0; vga_x2 = '0; vga_y2 = '0; vga_sof2 = 1'b0;
    m_rd = 1'b0; m_ready = 1'b0; m_drop = 8'd0;
    m_rd2 = 1'b0; m_ready2 = 1'b0; m_drop2 = 8'd0;
    tick(); tick();
    p_reset = 1'b1; p_reset2 = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_edges();
    test_tear_free();
    test_drop();
    test_simultaneous();
    test_drop_saturate();
    test_dec_rep();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cam_vga_fb.md
Name: cam_vga_fb

Overview:
- Parametrised camera-to-VGA frame buffer bridge. Generalises the fixed 128x128, 3x4-bit, single-bank capture window to configurable window size, channel count, offset, decimation and replication.
- Adds ping-pong double buffering with a tear-free bank swap on VGA frame start, and frame-drop accounting.
- Sits between the camera capture unit (pixel stream plus plot coordinates) and the VGA timing unit (scan coordinates) in the camera test top level.

Parameters:
- CH, 3, colour channels per pixel
- CW, 4, bits per channel
- WLG, 7, log2 window width in stored pixels
- HLG, 7, log2 window height in stored pixels
- DEC_SH, 0, camera decimation: a pixel is written only when the low DEC_SH bits of cam_x and of cam_y are both zero; stored index = coordinate >> DEC_SH
- REP_SH, 0, display replication: each stored pixel covers 2^REP_SH x 2^REP_SH screen pixels
- H_OFS, 7, screen x of window left edge (absorbs VGA pipeline skew)
- V_OFS, 0, screen y of window top edge
- BG, 0, CH*CW-bit value driven outside the window

Ports:
- m_clock  in  1  system clock
- p_reset  in  1  asynchronous active-low reset
- cam_x  in  10  camera plot x
- cam_y  in  10  camera plot y
- cam_valid  in  1  cam_pix/cam_x/cam_y valid this cycle
- cam_pix  in  CH*CW  packed pixel, channel 0 in LSBs
- cam_sof  in  1  one-cycle camera start-of-frame
- cam_eof  in  1  one-cycle camera end-of-frame
- vga_x  in  10  VGA scan x
- vga_y  in  10  VGA scan y
- vga_sof  in  1  one-cycle VGA start-of-frame (vsync)
- pix_out  out  CH*CW  display pixel
- pix_in_win  out  1  pix_out is sourced from memory
- rd_bank  out  1  bank currently displayed
- frame_ready  out  1  completed frame waiting for swap
- drop_cnt  out  8  saturating count of dropped camera frames

Behaviour:
- Reset: pix_out=BG, pix_in_win=0, rd_bank=0, wr_bank=1, frame_ready=0, drop_cnt=0, write FSM=IDLE. Memory contents are undefined after reset.
- Memory:
  - Depth 2^(WLG+HLG+1).
  - Address = {bank, yi[HLG-1:0], xi[WLG-1:0]}.
  - One write port, one read port; synchronous read with 1-cycle latency.
- Write FSM states: IDLE, FILL, HOLD.
  - IDLE: on cam_sof go to FILL.
  - FILL: cam_eof sets frame_ready=1 and goes to HOLD.
  - HOLD: on cam_sof with frame_ready=1, the frame is dropped: drop_cnt increments (saturating at 255), no writes occur, and the FSM stays in HOLD. On cam_sof with frame_ready=0, go to FILL.
- Write enable: requires state FILL, cam_valid=1, decimation bits zero, xi<2^WLG and yi<2^HLG. Coordinates outside the window are ignored; they never wrap into the window.
- Swap: on vga_sof with frame_ready=1:
  - rd_bank<=wr_bank, wr_bank<=rd_bank, frame_ready<=0.
  - Takes effect for the reads of the next cycle.
- Simultaneous events:
  - vga_sof and cam_eof in the same cycle: no swap this cycle; frame_ready becomes 1 and the swap happens at the next vga_sof.
  - vga_sof (with ready) and cam_sof in the same cycle: the swap wins and the new frame fills the freed bank. No drop is counted; the FSM goes to FILL.
  - cam_sof during FILL: restart the frame in the same bank (the previous frame is abandoned, not counted).
- Read side:
  - dx = vga_x - H_OFS and dy = vga_y - V_OFS, computed as 11-bit signed; a negative value means outside the window.
  - In window iff 0 <= dx < 2^(WLG+REP_SH) and 0 <= dy < 2^(HLG+REP_SH).
  - xi = dx >> REP_SH, yi = dy >> REP_SH, bank = rd_bank.
- Latency: vga_x/vga_y at cycle t -> pix_out/pix_in_win at t+2 (RAM read, then output register). The in-window flag is delayed 2 stages to match. Outside the window pix_out=BG.
- Reading and writing the same address is impossible by construction (different banks).

Decomposition:
- Shared package cam_fb_pkg: pixel width function CH*CW, coordinate width 10, BG default, address-concatenation helper.
- One sub-module, cam_fb_dpram: parametrised simple dual-port RAM (DW, AW, synchronous read, no reset).
- Write FSM, swap logic and read pipeline stay in cam_vga_fb.

Test Plan:
- Fill: reset; cam_sof; write cam_pix = {y[3:0],x[3:0],x[3:0]} for x,y<128; cam_eof; vga_sof -> rd_bank=1, frame_ready=0. vga_x=7+5, vga_y=3 gives pix_out=0x355 two cycles later, pix_in_win=1.
- Window edges: vga_x=6 or 135, or vga_y=128 -> pix_out=BG, pix_in_win=0. vga_x=7, vga_y=0 -> pixel (0,0). vga_x=0 must not alias (signed check).
- Tear-free: second frame written with constant 0xFFF, no vga_sof -> display still shows frame 1. After vga_sof -> 0xFFF everywhere in the window.
- Drop: cam_sof, cam_eof, cam_sof, cam_eof, cam_sof with no vga_sof -> drop_cnt=2, memory of the ready bank unchanged. Drive 300 drops -> drop_cnt=255.
- Simultaneous: vga_sof and cam_eof in the same cycle -> rd_bank unchanged, frame_ready=1; swap at the next vga_sof. vga_sof and cam_sof with ready -> swap, drop_cnt unchanged.
- Params CH=1, CW=8, WLG=6, HLG=6, DEC_SH=1, REP_SH=1: odd cam_x is not written; stored (3,2) appears at vga_x=H_OFS+6..7, vga_y=4..5. Assert p_reset mid-FILL -> all outputs return to their reset values.
